// File: rtl/bus_monitor_pkg.sv
// Shared definitions for the bus protocol monitor: violation codes, FSM states
// and the beat counter width.
package bus_monitor_pkg;

    localparam logic [2:0] NONE            = 3'd0;
    localparam logic [2:0] BEGIN_IN_ACTIVE = 3'd1;
    localparam logic [2:0] BEAT_IN_IDLE    = 3'd2;
    localparam logic [2:0] END_IN_IDLE     = 3'd3;
    localparam logic [2:0] BEAT_MISMATCH   = 3'd4;
    localparam logic [2:0] TIMEOUT         = 3'd5;
    localparam logic [2:0] BEAT_OVERFLOW   = 3'd6;

    localparam int BEAT_W = 9;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } busState_t;

    // When several violations coincide, the smallest code wins.
    function automatic logic [2:0] lowestCode(input logic [6:1] flags);
        lowestCode = NONE;
        for (int i = 6; i >= 1; i--) begin
            if (flags[i]) lowestCode = 3'(i);
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/bus_protocol_monitor.sv
// Passive observer of the system bus: tracks transactions, flags framing
// violations with a code and keeps saturating statistics. Never drives the bus.
module bus_protocol_monitor
    import bus_monitor_pkg::*;
#(
    parameter int timeoutCycles = 1024,
    parameter int countWidth    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           bus_addrData_i,
    input  logic [3:0]            bus_byteEnables_i,
    input  logic [7:0]            bus_burstSize_i,
    input  logic                  bus_readNWrite_i,
    input  logic                  bus_beginTransaction_i,
    input  logic                  bus_endTransaction_i,
    input  logic                  bus_dataValid_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_error_i,
    output logic                  violation_o,
    output logic [2:0]            violationCode_o,
    output logic [31:0]           violationAddr_o,
    output logic [countWidth-1:0] transactionCount_o,
    output logic [countWidth-1:0] readCount_o,
    output logic [countWidth-1:0] errorCount_o,
    output logic [countWidth-1:0] violationCount_o
);

    localparam int TO_W = $clog2(timeoutCycles);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeoutCycles - 1);

    busState_t         state, stateN;
    logic [BEAT_W-1:0] beatCnt, beatCntN;
    logic [TO_W-1:0]   toCnt, toCntN;
    logic [31:0]       capAddr;
    logic [7:0]        capBurst;
    logic              capRead;
    logic [3:0]        capBe;
    logic              ovflSeen, ovflSeenN;

    logic              beat, stillOpen, capture;
    logic              incTxn, incRead, incErr;
    logic [6:1]        flags;
    logic [BEAT_W:0]   beatTotal, beatTarget;
    logic              unusedBe;

    assign beat       = bus_dataValid_i & ~bus_busy_i;
    assign beatTotal  = {1'b0, beatCnt} + {{BEAT_W{1'b0}}, beat};
    assign beatTarget = {2'b00, capBurst} + 10'd1;
    assign unusedBe   = ^capBe;

    // Resolution order within a cycle: error, end, beat, timeout, begin.
    always_comb begin
        stillOpen = (state == ACTIVE);
        beatCntN  = beatCnt;
        toCntN    = toCnt;
        ovflSeenN = ovflSeen;
        flags     = '0;
        incTxn    = 1'b0;
        incRead   = 1'b0;
        incErr    = 1'b0;
        capture   = 1'b0;

        if (state == ACTIVE) begin
            if (bus_error_i) begin
                incErr    = 1'b1;
                stillOpen = 1'b0;
            end else if (bus_endTransaction_i) begin
                if (beatTotal != beatTarget) begin
                    flags[BEAT_MISMATCH] = 1'b1;
                end else begin
                    incTxn  = 1'b1;
                    incRead = capRead;
                end
                stillOpen = 1'b0;
            end else begin
                if (beat) begin
                    if (({1'b0, beatCnt} >= beatTarget) && !ovflSeen) begin
                        flags[BEAT_OVERFLOW] = 1'b1;
                        ovflSeenN            = 1'b1;
                    end
                    if (beatCnt != '1) beatCntN = beatCnt + 1'b1;
                end
                // toCnt reaches timeoutCycles on this edge.
                if (toCnt == TO_LAST) begin
                    flags[TIMEOUT] = 1'b1;
                    stillOpen      = 1'b0;
                end else begin
                    toCntN = toCnt + 1'b1;
                end
            end
        end else begin
            flags[END_IN_IDLE]  = bus_endTransaction_i;
            flags[BEAT_IN_IDLE] = beat;
        end

        if (bus_beginTransaction_i) begin
            flags[BEGIN_IN_ACTIVE] = stillOpen;
            capture   = 1'b1;
            beatCntN  = '0;
            toCntN    = '0;
            ovflSeenN = 1'b0;
            stillOpen = 1'b1;
        end

        stateN = stillOpen ? ACTIVE : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            beatCnt         <= '0;
            toCnt           <= '0;
            ovflSeen        <= 1'b0;
            capAddr         <= '0;
            capBurst        <= '0;
            capRead         <= 1'b0;
            capBe           <= '0;
            violation_o     <= 1'b0;
            violationCode_o <= NONE;
            violationAddr_o <= '0;
        end else begin
            state    <= stateN;
            beatCnt  <= beatCntN;
            toCnt    <= toCntN;
            ovflSeen <= ovflSeenN;
            if (capture) begin
                capAddr  <= bus_addrData_i;
                capBurst <= bus_burstSize_i;
                capRead  <= bus_readNWrite_i;
                capBe    <= bus_byteEnables_i;
            end
            violation_o <= |flags;
            if (|flags) begin
                violationCode_o <= lowestCode(flags);
                violationAddr_o <= (state == ACTIVE) ? capAddr : '0;
            end
        end
    end

    sat_counter #(.width(countWidth)) uTxnCount (
        .clk(clk_i), .rst(rst_i), .inc(incTxn), .value(transactionCount_o)
    );
    sat_counter #(.width(countWidth)) uReadCount (
        .clk(clk_i), .rst(rst_i), .inc(incRead), .value(readCount_o)
    );
    sat_counter #(.width(countWidth)) uErrCount (
        .clk(clk_i), .rst(rst_i), .inc(incErr), .value(errorCount_o)
    );
    sat_counter #(.width(countWidth)) uViolCount (
        .clk(clk_i), .rst(rst_i), .inc(|flags), .value(violationCount_o)
    );

endmodule

// File: doc/bus_protocol_monitor.md
Name: bus_protocol_monitor

Overview:
- Passive, simulation-and-synthesis-safe observer on the shared single-core system bus.
- Sits beside the memory, flash and print slaves in the single-core harness and SoC, consuming the same bus signals they receive plus the busy/error lines they produce.
- Tracks every transaction, checks beat count and framing rules, and detects hung transactions.
- Reports violations as a one-cycle pulse with a code, plus saturating statistics counters. It never drives the bus.

Parameters:
- timeoutCycles, 1024: max cycles a transaction may stay open before a timeout violation; minimum 2.
- countWidth, 32: width of the statistics counters, which saturate at all-ones.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- bus_addrData_i  in  32  address during begin, data during beats.
- bus_byteEnables_i  in  4  byte enables; sampled at begin for reporting only.
- bus_burstSize_i  in  8  beats minus one; sampled at begin.
- bus_readNWrite_i  in  1  1 = read; sampled at begin.
- bus_beginTransaction_i  in  1  start of transaction.
- bus_endTransaction_i  in  1  end of transaction.
- bus_dataValid_i  in  1  data beat present.
- bus_busy_i  in  1  OR of slave busy lines; a beat only counts when dataValid_i=1 and busy_i=0.
- bus_error_i  in  1  OR of slave error lines.
- violation_o  out  1  one-cycle pulse, one cycle after the offending edge.
- violationCode_o  out  3  code of the last violation; held until the next one.
- violationAddr_o  out  32  address captured at begin of the offending transaction; 0 if there was none.
- transactionCount_o  out  countWidth  transactions closed by an end.
- readCount_o  out  countWidth  closed read transactions.
- errorCount_o  out  countWidth  transactions aborted by bus_error_i.
- violationCount_o  out  countWidth  cycles in which at least one violation was flagged.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; beat counter, timeout counter and captured fields cleared. Reset mid-transaction discards the transaction silently, with no violation.
- FSM states: IDLE and ACTIVE.
- Begin: captures addr, burstSize, readNWrite, byteEnables; clears the beat counter (9 bits) and the timeout counter; enters ACTIVE.
- Per-cycle processing order: error, then end, then data beat, then timeout, then begin.
- Error: bus_error_i=1 in ACTIVE → errorCount_o+1 and go to IDLE. No beat-count check. Any end in the same cycle is ignored.
- End in ACTIVE:
  - If beats (including a same-cycle beat) differ from burstSize+1 → code 4.
  - Else transactionCount_o+1, and readCount_o+1 if it was a read.
  - Go to IDLE either way.
- End in IDLE → code 3.
- Beat in IDLE → code 2.
- Beat in ACTIVE:
  - If the beat would make beats > burstSize+1 → code 6, flagged once per transaction. The counter saturates at 511.
- Timeout: in ACTIVE with no end and no error, once the timeout counter reaches timeoutCycles → code 5 and force IDLE.
- Begin in ACTIVE while the current transaction is not closed this cycle → code 1. The old transaction is dropped uncounted and the new one is captured.
- Begin in the same cycle as a legal end is legal back-to-back: close the old transaction, then open the new one.
- Begin in IDLE, including a same-cycle end in IDLE, opens normally.
- Multiple violations in one cycle: the lowest code is reported; violationCount_o increments by 1.
- All outputs are registered. Counters saturate and never wrap.
- violationAddr_o is taken from the transaction the violation belongs to; codes 2 and 3 in IDLE report 0.

Decomposition:
- Shared package bus_monitor_pkg holds:
  - violation code constants: NONE=0, BEGIN_IN_ACTIVE=1, BEAT_IN_IDLE=2, END_IN_IDLE=3, BEAT_MISMATCH=4, TIMEOUT=5, BEAT_OVERFLOW=6;
  - the FSM state enum;
  - the beat-counter width constant (9).
- One sub-module, sat_counter (parameter width; ports clk/rst/inc/value), instantiated four times for the statistics counters.

Test Plan:
- Write, burstSize=3, 4 unstalled beats, then end → transactionCount_o=1, readCount_o=0, violation_o stays 0.
- Read, burstSize=0; beat held with busy_i=1 for 5 cycles, then accepted; end → readCount_o=1, no violation.
- Burst addr 0x04000010, burstSize=1, only 1 beat then end → violation_o pulses one cycle after end, code 4, violationAddr_o=0x04000010, violationCount_o=1.
- With timeoutCycles=16: begin, then nothing → code 5 exactly 16 cycles after begin; FSM is back in IDLE; next legal transaction counts normally.
- end and dataValid in IDLE on the same cycle → code 2 (lowest wins), violationCount_o+1 only.
- Begin, 2 beats, bus_error_i=1 together with end → errorCount_o=1, transactionCount_o unchanged, no violation.
- Assert rst_i mid-burst → all counters 0 and no pulse.
